// File: rtl/i2s_tx_frame_ctrl_if.sv
// Stereo sample stream from the upstream producer into the I2S transmit frame controller.
// The master drives valid and the left/right data; the slave answers with ready.
interface i2s_tx_frame_ctrl_if #(
  parameter int DATA_RES = 24
);
  logic                s_valid;
  logic                s_ready;
  logic [DATA_RES-1:0] s_ldata;
  logic [DATA_RES-1:0] s_rdata;

  modport master (
    output s_valid,
    output s_ldata,
    output s_rdata,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_ldata,
    input  s_rdata,
    output s_ready
  );
endinterface

// File: rtl/i2s_tx_frame_ctrl.sv
// I2S transmit frame sequencer: generates lrclk, stages one pending stereo pair and
// presents a stable left/right word pair to the serializer for each full frame.
module i2s_tx_frame_ctrl #(
  parameter int DATA_RES      = 24,
  parameter int SLOT_BITS     = 32,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                en,
  i2s_tx_frame_ctrl_if.slave  s_if,
  output logic                o_lrclk,
  output logic [DATA_RES-1:0] o_ldin,
  output logic [DATA_RES-1:0] o_rdin,
  output logic                o_valid,
  output logic                o_frame_start,
  output logic                o_underrun,
  output logic [15:0]         o_underrun_cnt
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                pend_full_q, pend_full_d;
  logic [DATA_RES-1:0] pend_l_q, pend_l_d;
  logic [DATA_RES-1:0] pend_r_q, pend_r_d;
  logic                lrclk_q, lrclk_d;
  logic [DATA_RES-1:0] ldin_q, ldin_d;
  logic [DATA_RES-1:0] rdin_q, rdin_d;
  logic                valid_q, valid_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;

  logic boundary;
  logic load;
  logic ready;
  logic accept;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    lrclk_d        = lrclk_q;
    ldin_d         = ldin_q;
    rdin_d         = rdin_q;
    valid_d        = valid_q;
    frame_start_d  = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    load           = 1'b0;
    ready          = 1'b0;
    boundary       = (state_q == RUN) && (bit_cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        valid_d   = 1'b0;
        lrclk_d   = 1'b0;
        bit_cnt_d = '0;
        if (en) begin
          state_d = PRIME;
        end
      end

      PRIME: begin
        ready = !pend_full_q;
        if (!en) begin
          state_d = IDLE;
        end else if (pend_full_q) begin
          load          = 1'b1;
          bit_cnt_d     = '0;
          lrclk_d       = 1'b0;
          valid_d       = 1'b1;
          frame_start_d = 1'b1;
          state_d       = RUN;
        end
      end

      RUN: begin
        // The buffer may take a new pair on the very edge it hands its current pair out.
        ready     = !pend_full_q || (boundary && en);
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        lrclk_d   = (bit_cnt_d >= SLOT_CNT);
        if (boundary) begin
          if (!en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            lrclk_d = 1'b0;
            ldin_d  = '0;
            rdin_d  = '0;
          end else begin
            frame_start_d = 1'b1;
            if (pend_full_q) begin
              load = 1'b1;
            end else begin
              underrun_d = 1'b1;
              if (underrun_cnt_q != 16'hFFFF) begin
                underrun_cnt_d = underrun_cnt_q + 16'd1;
              end
              if (UNDERRUN_MODE == 0) begin
                ldin_d = '0;
                rdin_d = '0;
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      ldin_d = pend_l_q;
      rdin_d = pend_r_q;
    end

    accept = s_if.s_valid && ready;

    // A transfer wins over a load so a same-edge hand-off keeps the buffer full.
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_l_d    = s_if.s_ldata;
      pend_r_d    = s_if.s_rdata;
    end else if (load) begin
      pend_full_d = 1'b0;
    end else begin
      pend_full_d = pend_full_q;
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      pend_full_q    <= 1'b0;
      pend_l_q       <= '0;
      pend_r_q       <= '0;
      lrclk_q        <= 1'b0;
      ldin_q         <= '0;
      rdin_q         <= '0;
      valid_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      pend_full_q    <= pend_full_d;
      pend_l_q       <= pend_l_d;
      pend_r_q       <= pend_r_d;
      lrclk_q        <= lrclk_d;
      ldin_q         <= ldin_d;
      rdin_q         <= rdin_d;
      valid_q        <= valid_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign s_if.s_ready   = ready;
  assign o_lrclk        = lrclk_q;
  assign o_ldin         = ldin_q;
  assign o_rdin         = rdin_q;
  assign o_valid        = valid_q;
  assign o_frame_start  = frame_start_q;
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// Bench for i2s_tx_frame_ctrl: mute and repeat variants share one stimulus stream and
// are checked every cycle against a frame-position model of the transmit sequencing.
module tb_i2s_tx_frame_ctrl;
  localparam int DR = 24;
  localparam int SB = 32;
  localparam int FL = 2 * SB;

  logic sclk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  always #5 sclk = ~sclk;

  i2s_tx_frame_ctrl_if #(.DATA_RES(DR)) if0 ();
  i2s_tx_frame_ctrl_if #(.DATA_RES(DR)) if1 ();
  assign if1.s_valid = if0.s_valid;
  assign if1.s_ldata = if0.s_ldata;
  assign if1.s_rdata = if0.s_rdata;

  logic          o_lrclk [2];
  logic [DR-1:0] o_ldin [2];
  logic [DR-1:0] o_rdin [2];
  logic          o_valid [2];
  logic          o_fs [2];
  logic          o_ur [2];
  logic [15:0]   o_cnt [2];

  i2s_tx_frame_ctrl #(.DATA_RES(DR), .SLOT_BITS(SB), .UNDERRUN_MODE(0)) dut0 (
    .sclk(sclk), .reset(reset), .en(en), .s_if(if0.slave),
    .o_lrclk(o_lrclk[0]), .o_ldin(o_ldin[0]), .o_rdin(o_rdin[0]), .o_valid(o_valid[0]),
    .o_frame_start(o_fs[0]), .o_underrun(o_ur[0]), .o_underrun_cnt(o_cnt[0])
  );

  i2s_tx_frame_ctrl #(.DATA_RES(DR), .SLOT_BITS(SB), .UNDERRUN_MODE(1)) dut1 (
    .sclk(sclk), .reset(reset), .en(en), .s_if(if1.slave),
    .o_lrclk(o_lrclk[1]), .o_ldin(o_ldin[1]), .o_rdin(o_rdin[1]), .o_valid(o_valid[1]),
    .o_frame_start(o_fs[1]), .o_underrun(o_ur[1]), .o_underrun_cnt(o_cnt[1])
  );

  int checks = 0;
  int failures = 0;

  // Model: 0 = stopped, 1 = waiting for a first pair, 2 = sequencing frames.
  int            m_mode = 0;
  int            m_pos = 0;
  logic [DR-1:0] pq_l [$];
  logic [DR-1:0] pq_r [$];
  logic [DR-1:0] w_l [2] = '{default: '0};
  logic [DR-1:0] w_r [2] = '{default: '0};
  int            m_cnt = 0;
  bit            m_fs = 1'b0;
  bit            m_ur = 1'b0;
  bit            last_acc = 1'b0;
  logic [DR-1:0] nval = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    if (m_mode == 1) return pq_l.size() == 0;
    if (m_mode == 2) return (pq_l.size() == 0) || ((m_pos == FL - 1) && en);
    return 1'b0;
  endfunction

  task automatic take_pending();
    for (int k = 0; k < 2; k++) begin
      w_l[k] = pq_l[0];
      w_r[k] = pq_r[0];
    end
    void'(pq_l.pop_front());
    void'(pq_r.pop_front());
  endtask

  task automatic model_edge(input bit acc, input logic [DR-1:0] al, input logic [DR-1:0] ar);
    m_fs = 1'b0;
    m_ur = 1'b0;
    if (reset) begin
      m_mode = 0;
      m_pos  = 0;
      m_cnt  = 0;
      pq_l.delete();
      pq_r.delete();
      w_l = '{default: '0};
      w_r = '{default: '0};
      return;
    end
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) m_mode = 0;
        else if (pq_l.size() != 0) begin
          take_pending();
          m_pos  = 0;
          m_mode = 2;
          m_fs   = 1'b1;
        end
      end
      default: begin
        if (m_pos == FL - 1) begin
          m_pos = 0;
          if (!en) begin
            m_mode = 0;
            w_l = '{default: '0};
            w_r = '{default: '0};
          end else begin
            m_fs = 1'b1;
            if (pq_l.size() != 0) take_pending();
            else begin
              m_ur = 1'b1;
              if (m_cnt < 65535) m_cnt++;
              w_l[0] = '0;
              w_r[0] = '0;
            end
          end
        end else begin
          m_pos++;
        end
      end
    endcase
    if (acc) begin
      pq_l.push_back(al);
      pq_r.push_back(ar);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d.lrclk", k), 32'(o_lrclk[k]), 32'((m_mode == 2) && (m_pos >= SB)));
      chk($sformatf("m%0d.valid", k), 32'(o_valid[k]), 32'(m_mode == 2));
      chk($sformatf("m%0d.ldin", k), 32'(o_ldin[k]), 32'(w_l[k]));
      chk($sformatf("m%0d.rdin", k), 32'(o_rdin[k]), 32'(w_r[k]));
      chk($sformatf("m%0d.frame_start", k), 32'(o_fs[k]), 32'(m_fs));
      chk($sformatf("m%0d.underrun", k), 32'(o_ur[k]), 32'(m_ur));
      chk($sformatf("m%0d.underrun_cnt", k), 32'(o_cnt[k]), 32'(m_cnt));
    end
  endtask

  // Inputs are already driven; check ready, clock once, advance the model, check outputs.
  task automatic cycle();
    bit rdy;
    #1;
    rdy = model_ready();
    chk("m0.s_ready", 32'(if0.s_ready), 32'(rdy));
    chk("m1.s_ready", 32'(if1.s_ready), 32'(rdy));
    last_acc = if0.s_valid && rdy && !reset;
    if (last_acc) $display("xfer L=%06h R=%06h pos=%0d", if0.s_ldata, if0.s_rdata, m_pos);
    @(posedge sclk);
    model_edge(if0.s_valid && rdy, if0.s_ldata, if0.s_rdata);
    @(negedge sclk);
    check_outputs();
  endtask

  task automatic stream_step(input bit use_valid);
    if0.s_valid = use_valid;
    if0.s_ldata = nval;
    if0.s_rdata = ~nval;
    cycle();
    if (last_acc) nval = nval + 1'b1;
  endtask

  task automatic wait_pos(input string tag, input int p, input bit use_valid, input bit need_pend);
    bit ok = 1'b0;
    for (int i = 0; i < 3 * FL && !ok; i++) begin
      stream_step(use_valid);
      if (m_mode == 2 && m_pos == p && (!need_pend || pq_l.size() != 0)) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    if0.s_valid = 1'b0;
    if0.s_ldata = '0;
    if0.s_rdata = '0;
    reset = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check_outputs();
    repeat (2) cycle();
    reset = 1'b0;
    cycle();

    // First pair, then no more samples: one real frame followed by underruns.
    en = 1'b1;
    cycle();
    if0.s_valid = 1'b1;
    if0.s_ldata = 24'hABCDEF;
    if0.s_rdata = 24'h123456;
    cycle();
    if0.s_valid = 1'b0;
    repeat (4 * FL) cycle();

    // Continuous incrementing stream.
    nval = 24'd1;
    repeat (6 * FL) stream_step(1'b1);

    // Drop en mid-frame with a pair pending, then resume from it.
    wait_pos("wait_pos10", 10, 1'b1, 1'b1);
    en = 1'b0;
    repeat (FL) stream_step(1'b0);
    en = 1'b1;
    repeat (2 * FL) stream_step(1'b1);

    // Reset mid-frame with a pair pending; the restart needs a fresh sample.
    wait_pos("wait_pos40", 40, 1'b1, 1'b1);
    reset = 1'b1;
    stream_step(1'b0);
    reset = 1'b0;
    repeat (20) stream_step(1'b0);
    stream_step(1'b1);
    repeat (3 * FL) stream_step(1'b0);

    // Underrun counter saturation.
    wait_pos("wait_pos5", 5, 1'b0, 1'b0);
    force dut0.underrun_cnt_q = 16'hFFFE;
    force dut1.underrun_cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    stream_step(1'b0);
    release dut0.underrun_cnt_q;
    release dut1.underrun_cnt_q;
    repeat (4 * FL) stream_step(1'b0);

    // Randomized traffic with en toggles and occasional resets.
    reset = 1'b1;
    stream_step(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      reset = ($urandom_range(0, 599) == 0);
      if0.s_valid = $urandom_range(0, 1) == 1;
      if0.s_ldata = DR'($urandom);
      if0.s_rdata = DR'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
